// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - pipelined decode stage: register file, immediates, load-use hazard, ID/EX register
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int BYPASS   = 1,
  parameter int RF_RESET = 1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] curr_pc_in,
  input  logic [XLEN-1:0] pc_plus_4_in,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic [2:0]      imm_src,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_rd1,
  output logic [XLEN-1:0] out_rd2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus_4,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            hazard_stall
);

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            wb_hit;
  logic [XLEN-1:0] rd1_val;
  logic [XLEN-1:0] rd2_val;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_val;
  logic            hazard;
  logic            advance;
  logic            load;

  // x0 has no storage; reads of address 0 are forced to zero below
  logic [XLEN-1:0] rf_mem [1:31];

  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign wb_hit = wb_we & (wb_rd != 5'd0);

  generate
    if (RF_RESET != 0) begin : g_rf_rst
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          for (int i = 1; i < 32; i++) rf_mem[i] <= '0;
        end else if (wb_hit) begin
          rf_mem[wb_rd] <= wb_data;
        end
      end
    end else begin : g_rf_norst
      always_ff @(posedge clk) begin
        if (wb_hit) rf_mem[wb_rd] <= wb_data;
      end
    end
  endgenerate

  always_comb begin
    rd1_val = '0;
    if (rs1 != 5'd0)
      rd1_val = (BYPASS != 0 && wb_hit && wb_rd == rs1) ? wb_data : rf_mem[rs1];
  end

  always_comb begin
    rd2_val = '0;
    if (rs2 != 5'd0)
      rd2_val = (BYPASS != 0 && wb_hit && wb_rd == rs2) ? wb_data : rf_mem[rs2];
  end

  // Build the 32-bit signed immediate first, then widen to XLEN by sign extension
  always_comb begin
    imm32 = '0;
    case (imm_src)
      3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011:  imm32 = {instr[31:12], 12'b0};
      3'b100:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_val = XLEN'($signed(imm32));

  // Conservative: rs2 is compared even for formats that do not read it
  assign hazard       = in_valid & ex_mem_read & (ex_rd != 5'd0) & ((ex_rd == rs1) | (ex_rd == rs2));
  assign hazard_stall = hazard;
  assign advance      = ex_ready | ~out_valid;
  assign in_ready     = flush | (advance & ~hazard);
  assign load         = ~flush & advance & in_valid & ~hazard;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid     <= 1'b0;
      out_rd1       <= '0;
      out_rd2       <= '0;
      out_imm       <= '0;
      out_pc        <= '0;
      out_pc_plus_4 <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_rd1       <= rd1_val;
      out_rd2       <= rd2_val;
      out_imm       <= imm_val;
      out_pc        <= curr_pc_in;
      out_pc_plus_4 <= pc_plus_4_in;
      out_rs1       <= rs1;
      out_rs2       <= rs2;
      out_rd        <= rd;
      out_reg_write <= reg_write;
      out_mem_read  <= mem_read;
    end else if (advance) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Pipelined, parametrised decode stage for the five-stage core; successor to the single-cycle decode stage. Decodes register fields, reads a 32-entry register file with optional write-to-read bypass, and sign-extends immediates to XLEN. Detects load-use hazards and inserts bubbles. Registers all results into an ID/EX pipeline register with a valid/ready handshake toward EX.

## Interface
- XLEN, 32, datapath width (32 or 64); immediates sign-extend from instr[31]
- BYPASS, 1, 1 = a WB write to the register being read is visible the same cycle; 0 = visible the next cycle
- RF_RESET, 1, 1 = all registers clear on n_rst; 0 = register contents are not reset
- clk  in  1  clock; all flops rise on posedge
- n_rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_ready  out  1  ID accepts the instruction this cycle
- instr  in  32  instruction word
- curr_pc_in, pc_plus_4_in  in  XLEN  PC and PC+4 of the instruction
- reg_write, mem_read  in  1  control-unit decode of instr
- imm_src  in  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J; other codes give 0
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination of the instruction in EX
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback register
- wb_data  in  XLEN  writeback data
- flush  in  1  branch or jump redirect; kills the ID/EX contents
- ex_ready  in  1  EX accepts the ID/EX contents
- out_valid  out  1  ID/EX register holds a valid instruction
- out_rd1, out_rd2, out_imm, out_pc, out_pc_plus_4  out  XLEN  registered operands
- out_rs1, out_rs2, out_rd  out  5  registered register addresses
- out_reg_write, out_mem_read  out  1  registered control signals
- hazard_stall  out  1  combinational load-use stall indicator

## Operation
- Register fields: rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
- Register file write:
  - On posedge when wb_we=1 and wb_rd≠0.
  - x0 is never written and always reads 0.
- Register file read:
  - If BYPASS=1, wb_we=1, wb_rd≠0 and wb_rd equals the source address, the read returns wb_data.
  - Otherwise the read returns the stored value.
- Immediate by format, then sign-extended to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- Load-use hazard:
  - hazard = in_valid & ex_mem_read & (ex_rd≠0) & (ex_rd==rs1 | ex_rd==rs2).
  - The check is conservative: both fields are compared regardless of format.
  - hazard_stall = hazard.
- Handshake terms:
  - advance = ex_ready | ~out_valid.
  - in_ready = flush | (advance & ~hazard).
- Posedge priority (highest first):
  - flush: out_valid←0. The offered instruction is consumed and dropped.
  - advance & in_valid & ~hazard: load all payload fields, out_valid←1.
  - advance otherwise: out_valid←0. A bubble is inserted and payload holds.
  - ~advance: all outputs hold.
- A held payload is not refreshed by later WB writes. EX-stage forwarding covers this case.

## Timing
- Reset (n_rst low, asynchronous):
  - out_valid=0.
  - All out_* payload = 0.
  - Registers = 0 when RF_RESET=1.
- Latency: instruction accepted in cycle N appears with out_valid=1 in cycle N+1.
- Throughput: one instruction per cycle when there is no hazard, no flush and ex_ready=1.
- A load in EX followed by a dependent instruction gives exactly one bubble, provided EX advances.
- WB write coincident with an ID read of the same register:
  - BYPASS=1: the new value is captured.
  - BYPASS=0: the old value is captured.
- flush coincident with hazard or ~ex_ready: flush wins, and out_valid=0 next cycle.
- n_rst deasserted mid-stream: the first accept is possible in the first cycle after release.

## Test plan
- Reset, then ADDI x1,x0,-5 (imm_src=000): next cycle out_valid=1, out_imm=0xFFFFFFFB, out_rd=1, out_rd1=0.
- wb_we=1, wb_rd=3, wb_data=0x1234 in the same cycle as an instruction with rs1=3:
  - BYPASS=1: out_rd1=0x1234.
  - BYPASS=0: out_rd1=old value; the next read returns 0x1234.
- ex_mem_read=1, ex_rd=5, instr rs2=5: hazard_stall=1, in_ready=0, one bubble (out_valid=0), then the instruction is accepted the following cycle.
- ex_ready=0 for 3 cycles with out_valid=1: outputs are stable, in_ready=0; the stream resumes with no loss or duplication.
- flush=1 while in_valid=1 and out_valid=1: next cycle out_valid=0, and the offered instruction never appears.
- Write to x0 with wb_data=0xFFFF, then read rs1=0: out_rd1=0. Check all five immediate formats at XLEN=64 for sign extension of 0x8-prefixed words.
